// File: rtl/bar_height_proc.sv
// Turns one 16-bin capture into 16 bar heights. Each bin is DC-removed, rectified,
// scaled, saturated and peak-held with linear decay; all heights are committed together.
module bar_height_proc #(
  parameter int unsigned NBINS      = 16,
  parameter int unsigned IN_W       = 18,
  parameter int unsigned H_W        = 9,
  parameter int unsigned OFFSET     = 2048,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned MAX_HEIGHT = 400,
  parameter int unsigned DECAY      = 8
) (
  input  logic                  clk_25,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NBINS*IN_W-1:0] bins_in,
  output logic                  busy,
  output logic                  done,
  output logic [NBINS*H_W-1:0]  bars_out
);

  localparam int unsigned IDX_W = $clog2(NBINS);
  localparam logic signed [IN_W:0] OFF_S = (IN_W+1)'(OFFSET);
  localparam logic [IN_W:0]        MAX_W = (IN_W+1)'(MAX_HEIGHT);

  typedef enum logic [1:0] {IDLE, PROC, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IN_W-1:0]  snap [NBINS];
  logic [H_W-1:0]   held [NBINS];
  logic [H_W-1:0]   work [NBINS];
  logic             commit_pend;

  logic [IN_W-1:0]       sample;
  logic signed [IN_W:0]  diff;
  logic [IN_W:0]         mag;
  logic [IN_W:0]         scaled;
  logic [H_W-1:0]        clipped;
  logic [H_W-1:0]        held_cur;
  logic [H_W-1:0]        decayed;
  logic [H_W-1:0]        bin_height;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = PROC;
      PROC:    if (idx == IDX_W'(NBINS-1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Height for the bin currently addressed by idx.
  always_comb begin
    sample     = snap[idx];
    diff       = $signed({1'b0, sample}) - OFF_S;
    mag        = diff[IN_W] ? $unsigned(-diff) : $unsigned(diff);
    scaled     = mag >> SHIFT;
    clipped    = (scaled > MAX_W) ? H_W'(MAX_HEIGHT) : scaled[H_W-1:0];
    held_cur   = held[idx];
    decayed    = (held_cur >= H_W'(DECAY)) ? (held_cur - H_W'(DECAY)) : '0;
    bin_height = '0;
    if (clipped >= held_cur)    bin_height = clipped;
    else if (clipped > decayed) bin_height = clipped;
    else                        bin_height = decayed;
  end

  // busy/done/bars_out are registered one stage behind the FSM, so done lands
  // 18 cycles after start and never overlaps busy; held leads bars_out by one cycle.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      commit_pend <= 1'b0;
      bars_out    <= '0;
      for (int unsigned i = 0; i < NBINS; i++) begin
        snap[i] <= '0;
        held[i] <= '0;
        work[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      busy        <= (state != IDLE);
      commit_pend <= (state == COMMIT);
      done        <= commit_pend;

      if (state == IDLE && start) begin
        idx <= '0;
        for (int unsigned i = 0; i < NBINS; i++)
          snap[i] <= bins_in[i*IN_W +: IN_W];
      end

      if (state == PROC) begin
        work[idx] <= bin_height;
        idx       <= idx + IDX_W'(1);
      end

      if (state == COMMIT) begin
        for (int unsigned i = 0; i < NBINS; i++)
          held[i] <= work[i];
      end

      if (commit_pend) begin
        for (int unsigned i = 0; i < NBINS; i++)
          bars_out[i*H_W +: H_W] <= held[i];
      end
    end
  end

endmodule

// File: tb/tb_bar_height_proc.sv
// Randomized + directed bench for bar_height_proc; a reference model predicts each
// committed frame and a monitor checks it when done pulses.
module tb_bar_height_proc;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [287:0] bins_in = '0;
  logic         busy, done;
  logic [143:0] bars_out;

  always #5 clk = ~clk;

  bar_height_proc #(
    .NBINS(16), .IN_W(18), .H_W(9), .OFFSET(2048),
    .SHIFT(2), .MAX_HEIGHT(400), .DECAY(8)
  ) dut (
    .clk_25(clk), .rst(rst), .start(start), .bins_in(bins_in),
    .busy(busy), .done(done), .bars_out(bars_out)
  );

  typedef struct {
    logic [143:0] bars;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           held_m [16];
  int           edge_n = 0;
  int           busy_until = 0;
  bit           rst_chk = 0;
  int           busy_cnt = 0;
  logic [143:0] last_bars = '0;
  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;

  function automatic int ref_height(input int s, input int held);
    int d, m, h, dec;
    d   = s - 2048;
    if (d < 0) d = -d;
    m   = d / 4;
    h   = (m > 400) ? 400 : m;
    dec = (held > 8) ? held - 8 : 0;
    if (h >= held) return h;
    return (h > dec) ? h : dec;
  endfunction

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decides acceptance from the 18-cycle run length and predicts the frame.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      for (int i = 0; i < 16; i++) held_m[i] = 0;
      exp_q.delete();
      busy_until = edge_n + 1;
      rst_chk = 1;
    end else if (start && edge_n >= busy_until) begin
      exp_t e;
      logic [17:0] s;
      for (int i = 0; i < 16; i++) begin
        s = bins_in[i*18 +: 18];
        held_m[i] = ref_height(int'(s), held_m[i]);
        e.bars[i*9 +: 9] = 9'(held_m[i]);
      end
      e.due = edge_n + 18;
      exp_q.push_back(e);
      busy_until = edge_n + 18;
    end
  end

  always @(negedge clk) begin
    if (rst_chk) begin
      check("reset_outputs", {bars_out, busy, done}, {144'd0, 1'b0, 1'b0});
      rst_chk = 0;
      busy_cnt = 0;
      last_bars = '0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {143'd0, done}, 144'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_latency", 144'(edge_n), 144'(e.due));
          check("frame", bars_out, e.bars);
          check("busy_in_done", {143'd0, busy}, 144'd0);
          check("busy_cycles", 144'(busy_cnt), 144'd17);
        end
        busy_cnt = 0;
        last_bars = bars_out;
      end else begin
        check("bars_stable", bars_out, last_bars);
        if (exp_q.size() != 0 && exp_q[0].due < edge_n) begin
          check("done_missing", 144'(edge_n), 144'(exp_q[0].due));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_all(input logic [17:0] v);
    for (int i = 0; i < 16; i++) bins_in[i*18 +: 18] = v;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: bins_in[i*18 +: 18] = 18'(348 + $urandom_range(0, 3400));
        1: bins_in[i*18 +: 18] = 18'($urandom);
        2: bins_in[i*18 +: 18] = 18'd2048;
        default: bins_in[i*18 +: 18] = 18'(2048 + 1590 + $urandom_range(0, 20));
      endcase
    end
  endtask

  task automatic expect_bars(input string name, input int b0, input int b1, input int b2, input int rest);
    logic [143:0] e;
    for (int i = 0; i < 16; i++) e[i*9 +: 9] = 9'(rest);
    e[0 +: 9]  = 9'(b0);
    e[9 +: 9]  = 9'(b1);
    e[18 +: 9] = 9'(b2);
    check(name, bars_out, e);
  endtask

  initial begin
    set_all(18'd2048);
    tick(3);
    rst = 1'b0;
    tick(2);

    // 1: all mid-scale
    pulse();
    tick(20);
    expect_bars("t1_zero", 0, 0, 0, 0);

    // 2: rectify both polarities and saturate
    set_all(18'd2048);
    bins_in[0 +: 18]  = 18'd2848;
    bins_in[18 +: 18] = 18'd1648;
    bins_in[36 +: 18] = 18'd200000;
    pulse();
    tick(20);
    expect_bars("t2_levels", 200, 100, 400, 0);

    // 3: linear decay over three frames
    set_all(18'd2048);
    for (int r = 1; r <= 3; r++) begin
      pulse();
      tick(20);
      expect_bars("t3_decay", 200 - 8*r, 100 - 8*r, 400 - 8*r, 0);
    end

    // 4: start while busy and late bins_in change are ignored
    set_random();
    pulse();
    set_random();
    tick(4);
    pulse();
    set_random();
    tick(22);

    // 5: reset mid-run aborts, next run starts from cleared heights
    set_all(18'd2048);
    bins_in[0 +: 18] = 18'd2848;
    pulse();
    tick(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_bars("t5_after_rst", 0, 0, 0, 0);
    tick(3);
    pulse();
    tick(20);
    expect_bars("t5_rerun", 200, 0, 0, 0);

    // 6: start held high gives back-to-back runs
    start = 1'b1;
    for (int c = 0; c < 90; c++) begin
      set_random();
      tick();
    end
    start = 1'b0;
    tick(20);

    // random starts at random spacing, some landing while busy
    for (int r = 0; r < 40; r++) begin
      set_random();
      pulse();
      tick($urandom_range(0, 24));
    end

    for (int w = 0; w < 40 && exp_q.size() != 0; w++) tick();
    check("queue_drained", 144'(exp_q.size()), 144'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
